hdd_sd_buffer: RTL and testbench

HDD_SD_BUFFER -- requirements
Module: hdd_sd_buffer

---
 rtl/hdd_buf_pkg.sv | 15 +
 rtl/sector_ram.sv | 29 ++
 rtl/hdd_sd_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_hdd_sd_buffer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdd_buf_pkg.sv
// Shared types and sizing constants for the HDD/SD sector buffer.
package hdd_buf_pkg;

    localparam int SECTOR_WORDS         = 128;
    localparam int HALFWORDS_PER_SECTOR = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SD_FILL,
        ST_HOST_DRAIN,
        ST_HOST_FILL,
        ST_SD_DRAIN
    } state_t;

endpackage

// File: rtl/sector_ram.sv
// One-sector word store: simple dual port, registered read, one-cycle latency.
module sector_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Storage array carries no reset; its contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered read port, cleared by reset so the read bus idles at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_rdata <= '0;
        else        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/hdd_sd_buffer.sv
// Sector buffer between an SD-card Avalon master and a 16-bit IDE-style host port.
// state       | meaning
// IDLE        | no transfer; SD stalled, host port closed
// SD_FILL     | SD master writes one sector into the buffer
// HOST_DRAIN  | host reads the sector as 256 halfwords
// HOST_FILL   | host writes one sector as 256 halfwords
// SD_DRAIN    | SD master reads the sector out of the buffer
module hdd_sd_buffer #(
    parameter int SECTOR_WORDS = hdd_buf_pkg::SECTOR_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_read,
    input  logic        start_write,
    input  logic [7:0]  sector_count,
    input  logic        abort,
    output logic        busy,
    output logic        drq,
    output logic        done,
    output logic        overrun,
    input  logic        sd_write,
    input  logic [31:0] sd_writedata,
    input  logic        sd_read,
    output logic [31:0] sd_readdata,
    output logic        sd_readdatavalid,
    output logic        sd_waitrequest,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [15:0] io_data_in,
    output logic [15:0] io_data_out
);

    import hdd_buf_pkg::*;

    localparam int             PTR_W     = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1;
    localparam logic [PTR_W-1:0] LAST_WORD = PTR_W'(SECTOR_WORDS - 1);

    state_t             r_state;
    logic [PTR_W-1:0]   r_word_ptr;
    logic               r_half;
    logic [8:0]         r_remaining;
    logic               r_drq;
    logic               r_done;
    logic               r_overrun;
    logic               r_rd_valid;
    logic [15:0]        r_lo_hold;

    logic               w_last_word;
    logic               w_we;
    logic [31:0]        w_wdata;
    logic [PTR_W-1:0]   w_raddr;
    logic [31:0]        w_rdata;

    assign w_last_word = (r_word_ptr == LAST_WORD);

    // Write port: whole SD words in SD_FILL; in HOST_FILL the low half is held
    // until the high half arrives so each word is written once.
    always_comb begin
        w_we    = 1'b0;
        w_wdata = sd_writedata;
        if (!abort) begin
            if (r_state == ST_SD_FILL && sd_write) begin
                w_we = 1'b1;
            end else if (r_state == ST_HOST_FILL && io_write && r_half) begin
                w_we    = 1'b1;
                w_wdata = {io_data_in, r_lo_hold};
            end
        end
    end

    // Read address looks one step ahead so the RAM output always tracks the
    // pointer; word 0 is pre-read during the fill so HOST_DRAIN starts valid.
    always_comb begin
        w_raddr = r_word_ptr;
        case (r_state)
            ST_IDLE, ST_SD_FILL: w_raddr = '0;
            ST_HOST_DRAIN: begin
                if (io_read && r_half && !w_last_word) w_raddr = r_word_ptr + 1'b1;
            end
            default: ;
        endcase
    end

    sector_ram #(
        .DEPTH (SECTOR_WORDS),
        .AW    (PTR_W),
        .DW    (32)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_word_ptr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Transfer sequencing, sector accounting and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_word_ptr  <= '0;
            r_half      <= 1'b0;
            r_remaining <= '0;
            r_drq       <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_lo_hold   <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            if (abort) begin
                r_state    <= ST_IDLE;
                r_drq      <= 1'b0;
                r_word_ptr <= '0;
                r_half     <= 1'b0;
            end else begin
                if ((sd_write && r_state != ST_SD_FILL) ||
                    (sd_read && r_state != ST_SD_DRAIN) ||
                    ((io_read || io_write) && !r_drq)) begin
                    r_overrun <= 1'b1;
                end
                case (r_state)
                    ST_IDLE: begin
                        if (start_read || start_write) begin
                            r_remaining <= (sector_count == 8'd0) ? 9'd256 : {1'b0, sector_count};
                            r_word_ptr  <= '0;
                            r_half      <= 1'b0;
                            r_overrun   <= 1'b0;
                            r_state     <= start_read ? ST_SD_FILL : ST_HOST_FILL;
                            r_drq       <= !start_read;
                        end
                    end
                    ST_SD_FILL: begin
                        if (sd_write) begin
                            if (w_last_word) begin
                                r_word_ptr <= '0;
                                r_state    <= ST_HOST_DRAIN;
                                r_drq      <= 1'b1;
                            end else begin
                                r_word_ptr <= r_word_ptr + 1'b1;
                            end
                        end
                    end
                    ST_HOST_DRAIN: begin
                        if (io_read) begin
                            r_half <= !r_half;
                            if (r_half) begin
                                if (w_last_word) begin
                                    r_word_ptr  <= '0;
                                    r_remaining <= r_remaining - 9'd1;
                                    r_drq       <= 1'b0;
                                    if (r_remaining == 9'd1) begin
                                        r_state <= ST_IDLE;
                                        r_done  <= 1'b1;
                                    end else begin
                                        r_state <= ST_SD_FILL;
                                    end
                                end else begin
                                    r_word_ptr <= r_word_ptr + 1'b1;
                                end
                            end
                        end
                    end
                    ST_HOST_FILL: begin
                        if (io_write) begin
                            r_half <= !r_half;
                            if (!r_half) begin
                                r_lo_hold <= io_data_in;
                            end else if (w_last_word) begin
                                r_word_ptr <= '0;
                                r_state    <= ST_SD_DRAIN;
                                r_drq      <= 1'b0;
                            end else begin
                                r_word_ptr <= r_word_ptr + 1'b1;
                            end
                        end
                    end
                    ST_SD_DRAIN: begin
                        if (sd_read) begin
                            r_rd_valid <= 1'b1;
                            if (w_last_word) begin
                                r_word_ptr  <= '0;
                                r_remaining <= r_remaining - 9'd1;
                                if (r_remaining == 9'd1) begin
                                    r_state <= ST_IDLE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= ST_HOST_FILL;
                                    r_drq   <= 1'b1;
                                end
                            end else begin
                                r_word_ptr <= r_word_ptr + 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy             = (r_state != ST_IDLE);
    assign drq              = r_drq;
    assign done             = r_done;
    assign overrun          = r_overrun;
    assign sd_waitrequest   = !(r_state == ST_SD_FILL || r_state == ST_SD_DRAIN);
    assign sd_readdatavalid = r_rd_valid;
    assign sd_readdata      = r_rd_valid ? w_rdata : 32'h0;
    assign io_data_out      = !r_drq ? 16'h0000 : (r_half ? w_rdata[31:16] : w_rdata[15:0]);

endmodule

// File: tb/tb_hdd_sd_buffer.sv
// Directed bench for hdd_sd_buffer: full-size instance plus a 4-word-sector
// instance used to walk a 256-sector transfer in reasonable time.
module tb_hdd_sd_buffer;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start_read, start_write, abort;
    logic [7:0]  sector_count;
    logic        busy, drq, done, overrun;
    logic        sd_write, sd_read, sd_readdatavalid, sd_waitrequest;
    logic [31:0] sd_writedata, sd_readdata;
    logic        io_read, io_write;
    logic [15:0] io_data_in, io_data_out;

    logic        s_start_read, s_start_write, s_abort;
    logic [7:0]  s_sector_count;
    logic        s_busy, s_drq, s_done, s_overrun;
    logic        s_sd_write, s_sd_read, s_sd_readdatavalid, s_sd_waitrequest;
    logic [31:0] s_sd_writedata, s_sd_readdata;
    logic        s_io_read, s_io_write;
    logic [15:0] s_io_data_in, s_io_data_out;

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    int n_s_done = 0;

    always #5 clk = ~clk;

    hdd_sd_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .start_read(start_read), .start_write(start_write),
        .sector_count(sector_count), .abort(abort),
        .busy(busy), .drq(drq), .done(done), .overrun(overrun),
        .sd_write(sd_write), .sd_writedata(sd_writedata),
        .sd_read(sd_read), .sd_readdata(sd_readdata),
        .sd_readdatavalid(sd_readdatavalid), .sd_waitrequest(sd_waitrequest),
        .io_read(io_read), .io_write(io_write),
        .io_data_in(io_data_in), .io_data_out(io_data_out)
    );

    hdd_sd_buffer #(.SECTOR_WORDS(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .start_read(s_start_read), .start_write(s_start_write),
        .sector_count(s_sector_count), .abort(s_abort),
        .busy(s_busy), .drq(s_drq), .done(s_done), .overrun(s_overrun),
        .sd_write(s_sd_write), .sd_writedata(s_sd_writedata),
        .sd_read(s_sd_read), .sd_readdata(s_sd_readdata),
        .sd_readdatavalid(s_sd_readdatavalid), .sd_waitrequest(s_sd_waitrequest),
        .io_read(s_io_read), .io_write(s_io_write),
        .io_data_in(s_io_data_in), .io_data_out(s_io_data_out)
    );

    always @(negedge clk) begin
        if (done)   n_done   <= n_done + 1;
        if (s_done) n_s_done <= n_s_done + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [15:0] hexp;
        int d0;
        int nsec;

        rst_n = 1'b0;
        start_read = 0; start_write = 0; abort = 0; sector_count = 0;
        sd_write = 0; sd_writedata = 0; sd_read = 0;
        io_read = 0; io_write = 0; io_data_in = 0;
        s_start_read = 0; s_start_write = 0; s_abort = 0; s_sector_count = 0;
        s_sd_write = 0; s_sd_writedata = 0; s_sd_read = 0;
        s_io_read = 0; s_io_write = 0; s_io_data_in = 0;

        // ---- reset values
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_drq", drq, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_wait", sd_waitrequest, 1);
        chk("rst_rdvalid", sd_readdatavalid, 0);
        chk("rst_rdata", sd_readdata, 0);
        chk("rst_io_out", io_data_out, 0);
        rst_n = 1'b1;
        tick();

        // ---- read one sector
        sector_count = 8'd1; start_read = 1; tick(); start_read = 0;
        chk("rd1_busy", busy, 1);
        chk("rd1_wait_fill", sd_waitrequest, 0);
        chk("rd1_drq_fill", drq, 0);
        for (int i = 0; i < 128; i++) begin
            sd_write = 1; sd_writedata = 32'h03020100 + 32'h04040404 * i; tick();
        end
        sd_write = 0;
        chk("rd1_drq", drq, 1);
        chk("rd1_wait_drain", sd_waitrequest, 1);
        d0 = n_done;
        for (int h = 0; h < 256; h++) begin
            w = 32'h03020100 + 32'h04040404 * (h / 2);
            hexp = (h % 2) ? w[31:16] : w[15:0];
            chk("rd1_half", io_data_out, hexp);
            io_read = 1; tick(); io_read = 0; tick();
        end
        chk("rd1_done_cnt", n_done - d0, 1);
        chk("rd1_busy_end", busy, 0);
        chk("rd1_drq_end", drq, 0);
        chk("rd1_io_zero", io_data_out, 0);
        chk("rd1_overrun", overrun, 0);

        // ---- write two sectors
        sector_count = 8'd2; start_write = 1; tick(); start_write = 0;
        chk("wr2_drq", drq, 1);
        chk("wr2_busy", busy, 1);
        d0 = n_done;
        for (int s = 0; s < 2; s++) begin
            for (int h = 0; h < 256; h++) begin
                io_data_in = 16'(s * 256 + h); io_write = 1; tick(); io_write = 0; tick();
            end
            chk("wr2_drq_drain", drq, 0);
            chk("wr2_wait_drain", sd_waitrequest, 0);
            chk("wr2_valid_idle", sd_readdatavalid, 0);
            sd_read = 1;
            for (int k = 0; k < 128; k++) begin
                tick();
                if (k == 127) sd_read = 0;
                chk("wr2_valid", sd_readdatavalid, 1);
                chk("wr2_word", sd_readdata, {16'(s * 256 + 2 * k + 1), 16'(s * 256 + 2 * k)});
            end
            tick();
            chk("wr2_valid_off", sd_readdatavalid, 0);
            if (s == 0) begin
                chk("wr2_mid_busy", busy, 1);
                chk("wr2_mid_drq", drq, 1);
                chk("wr2_mid_done", n_done - d0, 0);
            end else begin
                chk("wr2_end_busy", busy, 0);
                chk("wr2_end_done", n_done - d0, 1);
            end
        end
        chk("wr2_overrun", overrun, 0);

        // ---- stray accesses
        sector_count = 8'd1; start_read = 1; tick(); start_read = 0;
        for (int i = 0; i < 128; i++) begin
            sd_write = 1; sd_writedata = 32'hA5000000 + i; tick();
        end
        sd_write = 0;
        chk("stray_pre_ovr", overrun, 0);
        sd_write = 1; sd_writedata = 32'hFFFFFFFF; tick(); sd_write = 0;
        chk("stray_sdw_ovr", overrun, 1);
        chk("stray_drq", drq, 1);
        for (int h = 0; h < 256; h++) begin
            w = 32'hA5000000 + h / 2;
            hexp = (h % 2) ? w[31:16] : w[15:0];
            chk("stray_half", io_data_out, hexp);
            io_read = 1; tick(); io_read = 0; tick();
        end
        chk("stray_idle", busy, 0);
        io_read = 1; tick(); io_read = 0;
        chk("stray_ior_ovr", overrun, 1);
        chk("stray_io_zero", io_data_out, 0);
        sd_read = 1; tick(); sd_read = 0;
        chk("stray_sdr_valid", sd_readdatavalid, 0);
        d0 = n_done;
        sector_count = 8'd1; start_write = 1; tick(); start_write = 0;
        chk("stray_ovr_clear", overrun, 0);
        chk("stray_wr_drq", drq, 1);
        abort = 1; tick(); abort = 0;
        chk("stray_abort_busy", busy, 0);
        chk("stray_abort_drq", drq, 0);
        tick();
        chk("stray_abort_done", n_done - d0, 0);

        // ---- abort at word 60 of SD_FILL
        d0 = n_done;
        sector_count = 8'd1; start_read = 1; tick(); start_read = 0;
        for (int i = 0; i < 60; i++) begin
            sd_write = 1; sd_writedata = 32'h5A5A0000 + i; tick();
        end
        sd_write = 1; abort = 1; sd_writedata = 32'hDEADBEEF; tick();
        sd_write = 0; abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_drq", drq, 0);
        chk("abort_wait", sd_waitrequest, 1);
        chk("abort_ovr", overrun, 0);
        tick(); tick();
        chk("abort_no_done", n_done - d0, 0);

        // ---- reset during HOST_DRAIN
        sector_count = 8'd3; start_read = 1; tick(); start_read = 0;
        for (int i = 0; i < 128; i++) begin
            sd_write = 1; sd_writedata = 32'h10000000 + i; tick();
        end
        sd_write = 0;
        for (int h = 0; h < 4; h++) begin
            w = 32'h10000000 + h / 2;
            hexp = (h % 2) ? w[31:16] : w[15:0];
            chk("rst_mid_half", io_data_out, hexp);
            io_read = 1; tick(); io_read = 0; tick();
        end
        sd_write = 1; tick(); sd_write = 0;
        chk("rst_mid_ovr_set", overrun, 1);
        d0 = n_done;
        rst_n = 1'b0; #2;
        chk("rst2_busy", busy, 0);
        chk("rst2_drq", drq, 0);
        chk("rst2_done", done, 0);
        chk("rst2_overrun", overrun, 0);
        chk("rst2_wait", sd_waitrequest, 1);
        chk("rst2_rdvalid", sd_readdatavalid, 0);
        chk("rst2_rdata", sd_readdata, 0);
        chk("rst2_io_out", io_data_out, 0);
        tick(); rst_n = 1'b1; tick(); tick();
        chk("rst2_after_busy", busy, 0);
        chk("rst2_no_done", n_done - d0, 0);
        sector_count = 8'd1; start_read = 1; tick(); start_read = 0;
        for (int i = 0; i < 128; i++) begin
            sd_write = 1; sd_writedata = 32'h20000000 + i; tick();
        end
        sd_write = 0;
        chk("rst2_ptr_lo", io_data_out, 16'h0000);
        io_read = 1; tick(); io_read = 0; tick();
        chk("rst2_ptr_hi", io_data_out, 16'h2000);
        abort = 1; tick(); abort = 0;

        // ---- sector_count = 0 means 256 sectors (4-word sectors)
        s_sector_count = 8'd0; s_start_read = 1; tick(); s_start_read = 0;
        d0 = n_s_done;
        nsec = 0;
        while (s_busy && nsec < 300) begin
            for (int i = 0; i < 4; i++) begin
                s_sd_write = 1; s_sd_writedata = 32'h12345678 + i; tick();
            end
            s_sd_write = 0;
            if (nsec == 0) chk("cnt0_first_half", s_io_data_out, 16'h5678);
            for (int h = 0; h < 8; h++) begin
                s_io_read = 1; tick(); s_io_read = 0; tick();
            end
            nsec++;
            if (nsec == 255) begin
                chk("cnt0_busy_255", s_busy, 1);
                chk("cnt0_done_255", n_s_done - d0, 0);
            end
        end
        tick();
        chk("cnt0_sectors", nsec, 256);
        chk("cnt0_done", n_s_done - d0, 1);
        chk("cnt0_busy_end", s_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
